fpu_unpack: RTL and testbench
=============================

Name: fpu_unpack

Overview:
Issue-side front end of the FPU, at the opposite end of the pipeline from the normalize/pack stage.
- Accepts packed IEEE-754 single operands plus an opcode and destination from the decode stage.
- Unpacks each operand into sign, biased exponent and 24-bit mantissa with explicit hidden bit.
- Classifies special values and either dispatches to the add, mult or div datapath, or bypasses a finished special-case result directly to writeback.
- Two-stage pipeline with a ready/valid input handshake and a stall on divider busy.

Parameters:
- DEST_W, 5, destination register index width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid && in_ready
- in_op  in  2  0=add, 1=sub, 2=mul, 3=div
- in_a  in  32  packed operand A
- in_b  in  32  packed operand B
- in_dest  in  DEST_W  destination register
- div_busy  in  1  divider cannot accept a start this cycle
- add_start  out  1  one-cycle start pulse to adder
- mult_start  out  1  one-cycle start pulse to multiplier
- div_start  out  1  one-cycle start pulse to divider
- u_sign_a  out  1  unpacked sign of A
- u_exp_a  out  8  unpacked exponent of A
- u_mant_a  out  24  unpacked mantissa of A
- u_sign_b  out  1  unpacked sign of B, already inverted for sub
- u_exp_b  out  8  unpacked exponent of B
- u_mant_b  out  24  unpacked mantissa of B
- u_dest  out  DEST_W  destination travelling with the operands
- spec_valid  out  1  special-case result bypass valid
- spec_result  out  32  packed special-case result
- spec_dest  out  DEST_W  destination for the bypass result

Behaviour:
- Reset clears every valid, start and data register: all start pulses 0, spec_valid 0, u_* 0, spec_result 0, in_ready 1.
- S1 captures {op, a, b, dest} on accept.
- in_ready = !s1_valid || s1_adv.
- s1_adv = !(s1_op==div && !s1_special && div_busy).
- S2 outputs are registered. Latency is exactly 2 clocks from accept to start/spec pulse when no stall. Throughput is 1 op/clock.
- Unpack rule per operand:
  - exp==0: u_exp=1, mant={0,frac}.
  - Otherwise: u_exp=exp, mant={1,frac}.
- Operand B sign is inverted for sub.
- Special-case table, evaluated in S1, priority top-down. Matches assert spec_valid only, with no start pulse.
  - Any NaN input -> 0x7FC00000.
  - add/sub of inf and inf with opposite effective sign -> 0x7FC00000.
  - mul inf*0 -> NaN. div 0/0 and inf/inf -> NaN.
  - Any inf operand otherwise -> inf. Sign is the xor of signs for mul/div, the inf operand's effective sign for add/sub.
  - div x/0 (x finite nonzero) -> inf, sign xor.
  - mul with a zero operand -> zero, sign xor. div 0/x -> zero, sign xor.
- Otherwise exactly one of add_start (ops 0/1), mult_start or div_start pulses for one cycle.
- Zero + zero still goes to the adder, which handles sign-of-zero rules.
- Div stall:
  - S1 holds and S2 emits no pulse while div_busy=1.
  - A following accept is blocked (in_ready=0).
  - Start fires on the first cycle after div_busy drops.
- Special-case divs never stall.
- Reset mid-stall discards the held op; no pulse is issued afterwards.
- Starts are mutually exclusive with each other and with spec_valid in any cycle.

Optional Feature:
- FPU_DENORMAL_EN defined: denormals unpacked as described above (gradual underflow).
- Undefined (default): denormals-are-zero. Any input with exp==0 is treated as a signed zero before classification, e.g. 0x00000001 * 2.0 -> spec_result 0x00000000.

Decomposition:
- fpu_pkg holds:
  - fpu_op_t enum (ADD, SUB, MUL, DIV)
  - FPU_CANON_NAN=32'h7FC00000
  - fpu_class_t enum (ZERO, DENORM, NORMAL, INF, NAN)
  - fpu_unpacked_t struct {sign, exp[7:0], mant[23:0]}
- One combinational sub-module, fpu_classify, instanced twice: 32-bit input -> fpu_class_t plus fpu_unpacked_t (honours FPU_DENORMAL_EN).

Test Plan:
- add 0x3F800000+0x40000000 accepted cycle 0 -> add_start at cycle 2; u_exp_a=0x7F, u_mant_a=0x800000, u_exp_b=0x80, u_mant_b=0x800000.
- sub 1.0-1.0 -> add_start with u_sign_b=1.
- mul 0x7F800000*0x00000000 -> spec_valid, spec_result=0x7FC00000, no start pulse.
- div 0xBF800000/0x00000000 -> spec_result=0xFF800000.
- div 6.0/3.0 with div_busy=1 for 3 cycles:
  - in_ready=0 during the stall.
  - div_start fires the cycle after div_busy falls.
  - The next queued add follows one cycle later.
- mul 0x00400000*0x3F800000:
  - With FPU_DENORMAL_EN: mult_start, u_exp_a=1, u_mant_a=0x400000.
  - Without: spec_result=0x00000000.
- Back-to-back 4 adds -> 4 consecutive add_start pulses with dests in order.
- Reset asserted during a div stall -> no div_start afterwards.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared types for the FPU issue-side front end.
package fpu_pkg;

    localparam int unsigned FP_W   = 32;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MANT_W = 24;

    localparam logic [FP_W-1:0] FPU_CANON_NAN = 32'h7FC00000;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        MUL = 2'd2,
        DIV = 2'd3
    } fpu_op_t;

    typedef enum logic [2:0] {
        ZERO   = 3'd0,
        DENORM = 3'd1,
        NORMAL = 3'd2,
        INF    = 3'd3,
        NAN    = 3'd4
    } fpu_class_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fpu_unpacked_t;

endpackage

// File: rtl/fpu_classify.sv
// Classifies and unpacks one IEEE-754 single operand.
// FPU_DENORMAL_EN: when defined, denormals unpack with gradual underflow;
// otherwise every exp==0 input is flushed to a signed zero.
module fpu_classify
    import fpu_pkg::*;
(
    input  logic [FP_W-1:0] op_i,
    output fpu_class_t      cls_o,
    output fpu_unpacked_t   unp_o
);

    logic [EXP_W-1:0]  exp_f;
    logic [MANT_W-2:0] frac_f;

    assign exp_f  = op_i[30:23];
    assign frac_f = op_i[22:0];

    // Class decode and hidden-bit insertion; exp==0 maps to exponent 1.
    always_comb begin
        cls_o      = NORMAL;
        unp_o.sign = op_i[31];
        unp_o.exp  = exp_f;
        unp_o.mant = {1'b1, frac_f};
        if (exp_f == 8'h00) begin
            unp_o.exp = 8'd1;
`ifdef FPU_DENORMAL_EN
            unp_o.mant = {1'b0, frac_f};
            cls_o      = (frac_f == 23'd0) ? ZERO : DENORM;
`else
            unp_o.mant = 24'd0;
            cls_o      = ZERO;
`endif
        end else if (exp_f == 8'hFF) begin
            cls_o = (frac_f == 23'd0) ? INF : NAN;
        end
    end

endmodule

// File: rtl/fpu_unpack.sv
// FPU issue front end: two-stage unpack/classify with special-case bypass.
// FPU_DENORMAL_EN selects gradual underflow (default: denormals-are-zero).
module fpu_unpack
    import fpu_pkg::*;
#(
    parameter int unsigned DEST_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [FP_W-1:0]   in_a,
    input  logic [FP_W-1:0]   in_b,
    input  logic [DEST_W-1:0] in_dest,
    input  logic              div_busy,
    output logic              add_start,
    output logic              mult_start,
    output logic              div_start,
    output logic              u_sign_a,
    output logic [EXP_W-1:0]  u_exp_a,
    output logic [MANT_W-1:0] u_mant_a,
    output logic              u_sign_b,
    output logic [EXP_W-1:0]  u_exp_b,
    output logic [MANT_W-1:0] u_mant_b,
    output logic [DEST_W-1:0] u_dest,
    output logic              spec_valid,
    output logic [FP_W-1:0]   spec_result,
    output logic [DEST_W-1:0] spec_dest
);

    logic              s1_valid_q;
    fpu_op_t           s1_op_q;
    logic [FP_W-1:0]   s1_a_q;
    logic [FP_W-1:0]   s1_b_q;
    logic [DEST_W-1:0] s1_dest_q;

    fpu_class_t    cls_a, cls_b;
    fpu_unpacked_t unp_a, unp_b;

    logic            special_d;
    logic [FP_W-1:0] spec_res_d;
    logic            sign_b_eff;
    logic            s1_adv;
    logic            fire;

    logic              add_q, mult_q, div_q, spec_valid_q;
    fpu_unpacked_t     ua_q, ub_q;
    logic [DEST_W-1:0] u_dest_q, spec_dest_q;
    logic [FP_W-1:0]   spec_result_q;

    fpu_classify u_cls_a (.op_i(s1_a_q), .cls_o(cls_a), .unp_o(unp_a));
    fpu_classify u_cls_b (.op_i(s1_b_q), .cls_o(cls_b), .unp_o(unp_b));

    assign sign_b_eff = unp_b.sign ^ (s1_op_q == SUB);

    // Special-case table, highest priority first.
    always_comb begin
        logic nan_any, inf_a, inf_b, zero_a, zero_b, addsub, is_mul, is_div, sxor;
        nan_any    = (cls_a == NAN) || (cls_b == NAN);
        inf_a      = (cls_a == INF);
        inf_b      = (cls_b == INF);
        zero_a     = (cls_a == ZERO);
        zero_b     = (cls_b == ZERO);
        addsub     = (s1_op_q == ADD) || (s1_op_q == SUB);
        is_mul     = (s1_op_q == MUL);
        is_div     = (s1_op_q == DIV);
        sxor       = unp_a.sign ^ unp_b.sign;
        special_d  = 1'b1;
        spec_res_d = FPU_CANON_NAN;
        if (nan_any) begin
            spec_res_d = FPU_CANON_NAN;
        end else if (addsub && inf_a && inf_b && (unp_a.sign != sign_b_eff)) begin
            spec_res_d = FPU_CANON_NAN;
        end else if (is_mul && ((inf_a && zero_b) || (zero_a && inf_b))) begin
            spec_res_d = FPU_CANON_NAN;
        end else if (is_div && ((zero_a && zero_b) || (inf_a && inf_b))) begin
            spec_res_d = FPU_CANON_NAN;
        end else if (inf_a || inf_b) begin
            spec_res_d = {(addsub ? (inf_a ? unp_a.sign : sign_b_eff) : sxor), 8'hFF, 23'd0};
        end else if (is_div && zero_b) begin
            spec_res_d = {sxor, 8'hFF, 23'd0};
        end else if ((is_mul && (zero_a || zero_b)) || (is_div && zero_a)) begin
            spec_res_d = {sxor, 31'd0};
        end else begin
            special_d  = 1'b0;
            spec_res_d = 32'd0;
        end
    end

    assign s1_adv   = !((s1_op_q == DIV) && !special_d && div_busy);
    assign in_ready = !s1_valid_q || s1_adv;
    assign fire     = s1_valid_q && s1_adv;

    // Stage 1: capture the offered operation on accept, hold while stalled.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= ADD;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_dest_q  <= '0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_op_q   <= fpu_op_t'(in_op);
                s1_a_q    <= in_a;
                s1_b_q    <= in_b;
                s1_dest_q <= in_dest;
            end
        end
    end

    // Stage 2: registered dispatch pulses, unpacked operands and bypass result.
    always_ff @(posedge clock) begin
        if (reset) begin
            add_q         <= 1'b0;
            mult_q        <= 1'b0;
            div_q         <= 1'b0;
            spec_valid_q  <= 1'b0;
            ua_q          <= '0;
            ub_q          <= '0;
            u_dest_q      <= '0;
            spec_result_q <= '0;
            spec_dest_q   <= '0;
        end else begin
            add_q        <= fire && !special_d && ((s1_op_q == ADD) || (s1_op_q == SUB));
            mult_q       <= fire && !special_d && (s1_op_q == MUL);
            div_q        <= fire && !special_d && (s1_op_q == DIV);
            spec_valid_q <= fire && special_d;
            if (fire && !special_d) begin
                ua_q      <= unp_a;
                ub_q      <= '{sign: sign_b_eff, exp: unp_b.exp, mant: unp_b.mant};
                u_dest_q  <= s1_dest_q;
            end
            if (fire && special_d) begin
                spec_result_q <= spec_res_d;
                spec_dest_q   <= s1_dest_q;
            end
        end
    end

    assign add_start   = add_q;
    assign mult_start  = mult_q;
    assign div_start   = div_q;
    assign spec_valid  = spec_valid_q;
    assign u_sign_a    = ua_q.sign;
    assign u_exp_a     = ua_q.exp;
    assign u_mant_a    = ua_q.mant;
    assign u_sign_b    = ub_q.sign;
    assign u_exp_b     = ub_q.exp;
    assign u_mant_b    = ub_q.mant;
    assign u_dest      = u_dest_q;
    assign spec_result = spec_result_q;
    assign spec_dest   = spec_dest_q;

endmodule

// File: tb/tb_fpu_unpack.sv
// Directed self-checking bench for fpu_unpack.
module tb_fpu_unpack;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_a, in_b;
    logic [4:0]  in_dest;
    logic        div_busy;
    logic        add_start, mult_start, div_start;
    logic        u_sign_a, u_sign_b;
    logic [7:0]  u_exp_a, u_exp_b;
    logic [23:0] u_mant_a, u_mant_b;
    logic [4:0]  u_dest, spec_dest;
    logic        spec_valid;
    logic [31:0] spec_result;

    int n_cmp = 0;
    int n_err = 0;

    fpu_unpack #(.DEST_W(5)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_dest(in_dest), .div_busy(div_busy),
        .add_start(add_start), .mult_start(mult_start), .div_start(div_start),
        .u_sign_a(u_sign_a), .u_exp_a(u_exp_a), .u_mant_a(u_mant_a),
        .u_sign_b(u_sign_b), .u_exp_b(u_exp_b), .u_mant_b(u_mant_b),
        .u_dest(u_dest), .spec_valid(spec_valid), .spec_result(spec_result),
        .spec_dest(spec_dest)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    // Drive at a negedge, present for one cycle, return at the negedge where S2 is visible.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] dest);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_dest = dest;
        step();
        in_valid = 1'b0;
        step();
    endtask

    task automatic chk_starts(input string tag, input logic a, input logic m, input logic d,
                              input logic s);
        chk({tag, ".add"},  32'(add_start),  32'(a));
        chk({tag, ".mult"}, 32'(mult_start), 32'(m));
        chk({tag, ".div"},  32'(div_start),  32'(d));
        chk({tag, ".spec"}, 32'(spec_valid), 32'(s));
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_op = 2'd0; in_a = '0; in_b = '0;
        in_dest = '0; div_busy = 1'b0;
        step(); step();
        chk_starts("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.ready", 32'(in_ready), 32'h1);
        chk("reset.expa", 32'(u_exp_a), 32'h0);
        chk("reset.res", spec_result, 32'h0);
        reset = 1'b0;
        step();

        // add 1.0 + 2.0, latency 2
        in_valid = 1'b1; in_op = 2'd0; in_a = 32'h3F800000; in_b = 32'h40000000; in_dest = 5'd3;
        step();
        in_valid = 1'b0;
        chk("add.lat1", 32'(add_start), 32'h0);
        step();
        chk_starts("add", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("add.expa", 32'(u_exp_a), 32'h7F);
        chk("add.manta", 32'(u_mant_a), 32'h800000);
        chk("add.expb", 32'(u_exp_b), 32'h80);
        chk("add.mantb", 32'(u_mant_b), 32'h800000);
        chk("add.signb", 32'(u_sign_b), 32'h0);
        chk("add.dest", 32'(u_dest), 32'h3);
        step();
        chk("add.pulse1", 32'(add_start), 32'h0);

        // sub 1.0 - 1.0: B sign inverted
        issue(2'd1, 32'h3F800000, 32'h3F800000, 5'd4);
        chk_starts("sub", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("sub.signb", 32'(u_sign_b), 32'h1);
        chk("sub.signa", 32'(u_sign_a), 32'h0);

        // mul inf * 0 -> NaN
        issue(2'd2, 32'h7F800000, 32'h00000000, 5'd5);
        chk_starts("mulinf0", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("mulinf0.res", spec_result, 32'h7FC00000);
        chk("mulinf0.dest", 32'(spec_dest), 32'h5);

        // div -1 / 0 -> -inf
        issue(2'd3, 32'hBF800000, 32'h00000000, 5'd6);
        chk_starts("divx0", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("divx0.res", spec_result, 32'hFF800000);

        // NaN operand
        issue(2'd0, 32'h7FC00001, 32'h3F800000, 5'd1);
        chk("nan.res", spec_result, 32'h7FC00000);
        // inf - inf (same sign) -> NaN
        issue(2'd1, 32'h7F800000, 32'h7F800000, 5'd1);
        chk("infsub.res", spec_result, 32'h7FC00000);
        // 1.0 - (-inf) -> +inf
        issue(2'd1, 32'h3F800000, 32'hFF800000, 5'd1);
        chk("subninf.res", spec_result, 32'h7F800000);
        // -2.0 * 0 -> -0
        issue(2'd2, 32'hC0000000, 32'h00000000, 5'd1);
        chk("mulzero.res", spec_result, 32'h80000000);
        // 2.0 * 3.0 -> multiplier
        issue(2'd2, 32'h40000000, 32'h40400000, 5'd9);
        chk_starts("mul", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("mul.mantb", 32'(u_mant_b), 32'hC00000);

        // div 6.0/3.0 with div_busy for 3 cycles, then a queued add
        in_valid = 1'b1; in_op = 2'd3; in_a = 32'h40C00000; in_b = 32'h40400000; in_dest = 5'd8;
        div_busy = 1'b1;
        chk("stall.ready0", 32'(in_ready), 32'h1);
        step();
        in_op = 2'd0; in_a = 32'h3F800000; in_b = 32'h3F800000; in_dest = 5'd7;
        chk("stall.ready1", 32'(in_ready), 32'h0);
        step();
        chk("stall.ready2", 32'(in_ready), 32'h0);
        chk("stall.nodiv2", 32'(div_start), 32'h0);
        step();
        chk("stall.ready3", 32'(in_ready), 32'h0);
        chk_starts("stall3", 1'b0, 1'b0, 1'b0, 1'b0);
        div_busy = 1'b0;
        step();
        in_valid = 1'b0;
        chk_starts("divgo", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("divgo.expa", 32'(u_exp_a), 32'h81);
        chk("divgo.expb", 32'(u_exp_b), 32'h80);
        chk("divgo.dest", 32'(u_dest), 32'h8);
        step();
        chk_starts("afterdiv", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("afterdiv.dest", 32'(u_dest), 32'h7);

        // denormal A
        issue(2'd2, 32'h00400000, 32'h3F800000, 5'd2);
`ifdef FPU_DENORMAL_EN
        chk_starts("denorm", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("denorm.expa", 32'(u_exp_a), 32'h1);
        chk("denorm.manta", 32'(u_mant_a), 32'h400000);
`else
        chk_starts("daz", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("daz.res", spec_result, 32'h00000000);
`endif

        // four back-to-back adds
        in_valid = 1'b1; in_op = 2'd0; in_a = 32'h3F800000; in_b = 32'h40000000;
        in_dest = 5'd10; step();
        in_dest = 5'd11; step();
        in_dest = 5'd12;
        chk("b2b0.add", 32'(add_start), 32'h1);
        chk("b2b0.dest", 32'(u_dest), 32'd10);
        step();
        in_dest = 5'd13;
        chk("b2b1.add", 32'(add_start), 32'h1);
        chk("b2b1.dest", 32'(u_dest), 32'd11);
        step();
        in_valid = 1'b0;
        chk("b2b2.add", 32'(add_start), 32'h1);
        chk("b2b2.dest", 32'(u_dest), 32'd12);
        step();
        chk("b2b3.add", 32'(add_start), 32'h1);
        chk("b2b3.dest", 32'(u_dest), 32'd13);
        step();
        chk("b2b.end", 32'(add_start), 32'h0);

        // reset during a div stall discards the op
        in_valid = 1'b1; in_op = 2'd3; in_a = 32'h40C00000; in_b = 32'h40400000; in_dest = 5'd15;
        div_busy = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0; div_busy = 1'b0;
        chk("rststall.ready", 32'(in_ready), 32'h1);
        for (int i = 0; i < 4; i++) begin
            chk("rststall.nodiv", 32'(div_start), 32'h0);
            chk("rststall.nospec", 32'(spec_valid), 32'h0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
